// File: rtl/fpmul_rr_arbiter.sv
// rtl/fpmul_rr_arbiter.sv - round-robin sharing of one FP multiplier among NUM_REQ requesters
// Sequences start/done, holds operands during the multiply, and forces a response on watchdog expiry.
module fpmul_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [31:0]           rsp_product_o,
  output logic [4:0]            rsp_flags_o,
  output logic                  busy_o,
  output logic [31:0]           mul_a_o,
  output logic [31:0]           mul_b_o,
  output logic                  mul_start_o,
  input  logic                  mul_done_i,
  input  logic                  mul_nan_i,
  input  logic                  mul_inf_i,
  input  logic                  mul_ovf_i,
  input  logic                  mul_udf_i,
  input  logic [31:0]           mul_product_i
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_gnt;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_sel;
  logic          w_any;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  int            w_idx;

  // First valid requester after the last one served, wrapping around.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    w_idx  = 0;
    w_sel  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = int'(r_last) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_sel = w_idx[IW-1:0];
      if (!w_any && req_valid_i[w_sel]) begin
        w_any  = 1'b1;
        w_pick = w_sel;
      end
    end
  end

  // r_cnt holds the number of cycles elapsed since the start pulse.
  assign w_timeout   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign busy_o      = (r_state != S_IDLE);
  assign mul_start_o = (r_state == S_ISSUE);

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (rst_n && (r_state == S_IDLE) && w_any) begin
      req_ready_o[w_pick] = 1'b1;
    end
    if (r_state == S_RESP) begin
      rsp_valid_o[r_gnt] = 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (mul_done_i || w_timeout) w_next = S_RESP;
      S_RESP:  if (rsp_ready_i[r_gnt]) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last        <= IW'(NUM_REQ - 1);
      r_gnt         <= '0;
      r_cnt         <= '0;
      mul_a_o       <= '0;
      mul_b_o       <= '0;
      rsp_product_o <= '0;
      rsp_flags_o   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick;
            mul_a_o <= req_a_i[32*w_pick +: 32];
            mul_b_o <= req_b_i[32*w_pick +: 32];
          end
        end
        S_ISSUE: r_cnt <= CW'(1);
        S_WAIT: begin
          if (mul_done_i) begin
            rsp_product_o <= mul_product_i;
            rsp_flags_o   <= {1'b0, mul_udf_i, mul_ovf_i, mul_inf_i, mul_nan_i};
          end else if (w_timeout) begin
            rsp_product_o <= 32'h7FC0_0000;
            rsp_flags_o   <= 5'b10000;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i[r_gnt]) begin
            r_last <= r_gnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// tb/tb_fpmul_rr_arbiter.sv - self-checking bench for fpmul_rr_arbiter with a multiplier stub
// A transaction-level model predicts grants, start pulses, response timing and payload every cycle.
module tb_fpmul_rr_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*32-1:0] req_a_i;
  logic [N*32-1:0] req_b_i;
  logic [N-1:0]   rsp_valid_o;
  logic [N-1:0]   rsp_ready_i;
  logic [31:0]    rsp_product_o;
  logic [4:0]     rsp_flags_o;
  logic           busy_o;
  logic [31:0]    mul_a_o;
  logic [31:0]    mul_b_o;
  logic           mul_start_o;
  logic           mul_done_i;
  logic           mul_nan_i;
  logic           mul_inf_i;
  logic           mul_ovf_i;
  logic           mul_udf_i;
  logic [31:0]    mul_product_i;

  fpmul_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_product_o(rsp_product_o), .rsp_flags_o(rsp_flags_o),
    .busy_o(busy_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_start_o(mul_start_o), .mul_done_i(mul_done_i),
    .mul_nan_i(mul_nan_i), .mul_inf_i(mul_inf_i),
    .mul_ovf_i(mul_ovf_i), .mul_udf_i(mul_udf_i),
    .mul_product_i(mul_product_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Multiplier stub: fixed payload/latency for directed cases, random otherwise; delay 0 never answers.
  bit          stub_fixed;
  int          stub_delay;
  logic [31:0] stub_prod;
  logic [3:0]  stub_flg;

  initial begin : stub
    int          st_cnt;
    logic [31:0] st_prod;
    logic [3:0]  st_flg;
    st_cnt = 0;
    st_prod = '0;
    st_flg = '0;
    mul_done_i = 1'b0;
    mul_product_i = '0;
    {mul_udf_i, mul_ovf_i, mul_inf_i, mul_nan_i} = 4'b0;
    forever begin
      @(negedge clk);
      if (rst_n && mul_start_o) begin
        if (stub_fixed) begin
          st_cnt  = stub_delay;
          st_prod = stub_prod;
          st_flg  = stub_flg;
        end else begin
          st_cnt  = $urandom_range(1, 18);
          st_prod = 32'(mul_a_o * mul_b_o);
          st_flg  = 4'($urandom);
        end
      end
      step();
      mul_done_i = 1'b0;
      mul_product_i = $urandom;
      {mul_udf_i, mul_ovf_i, mul_inf_i, mul_nan_i} = 4'($urandom);
      if (st_cnt == 1) begin
        mul_done_i = 1'b1;
        mul_product_i = st_prod;
        {mul_udf_i, mul_ovf_i, mul_inf_i, mul_nan_i} = st_flg;
        st_cnt = 0;
      end else if (st_cnt > 1) begin
        st_cnt--;
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  bit          m_busy;
  int          m_g, m_t, m_rsp, m_last;
  logic [31:0] m_a, m_b, m_prod;
  logic [4:0]  m_flg;
  int          grants[$];
  int          n_starts = 0;

  always @(negedge clk) begin : model
    logic [N-1:0] exp_ready;
    int g;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = N - 1;
    end else begin
      exp_ready = '0;
      if (mul_start_o) n_starts++;
      chk("ready_onehot", ($countones(req_ready_o) <= 1), 1);
      if (!m_busy) begin
        g = rr_pick(req_valid_i, m_last);
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready_o, exp_ready);
        chk("busy_idle", busy_o, 0);
        chk("start_idle", mul_start_o, 0);
        chk("rsp_valid_idle", rsp_valid_o, 0);
        if (g >= 0) begin
          m_busy = 1'b1;
          m_g    = g;
          m_a    = req_a_i[32*g +: 32];
          m_b    = req_b_i[32*g +: 32];
          m_t    = cyc;
          m_rsp  = 0;
          grants.push_back(g);
        end
      end else begin
        chk("req_ready_busy", req_ready_o, 0);
        chk("busy", busy_o, 1);
        chk("start_pulse", mul_start_o, (cyc == m_t + 1));
        chk("mul_a", mul_a_o, m_a);
        chk("mul_b", mul_b_o, m_b);
        if (m_rsp == 0) begin
          chk("rsp_valid_early", rsp_valid_o, 0);
          if (cyc >= m_t + 2 && mul_done_i) begin
            m_rsp  = cyc + 1;
            m_prod = mul_product_i;
            m_flg  = {1'b0, mul_udf_i, mul_ovf_i, mul_inf_i, mul_nan_i};
          end else if (cyc == m_t + TO) begin
            m_rsp  = cyc + 1;
            m_prod = 32'h7FC0_0000;
            m_flg  = 5'b10000;
          end
        end else begin
          exp_ready = '0;
          exp_ready[m_g] = 1'b1;
          chk("rsp_valid", rsp_valid_o, exp_ready);
          chk("rsp_product", rsp_product_o, m_prod);
          chk("rsp_flags", rsp_flags_o, m_flg);
          if (rsp_ready_i[m_g]) begin
            m_last = m_g;
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_product"}, rsp_product_o, 0);
    chk({tag, "_flags"}, rsp_flags_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_mul_a"}, mul_a_o, 0);
    chk({tag, "_mul_b"}, mul_b_o, 0);
    chk({tag, "_start"}, mul_start_o, 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (!busy_o) ok = 1'b1;
    end
    chk("idle_reached", ok, 1);
    step();
  endtask

  task automatic run_txn(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input int dly, input int hold, input logic [N-1:0] bg,
                         output int t_acc, output int t_rsp, output logic [31:0] p,
                         output logic [4:0] f, output logic [N-1:0] v);
    t_acc = -1;
    t_rsp = -1;
    p = '0;
    f = '0;
    v = '0;
    stub_fixed = 1'b1;
    stub_delay = dly;
    req_a_i[32*idx +: 32] = a;
    req_b_i[32*idx +: 32] = b;
    req_valid_i = '0;
    req_valid_i[idx] = 1'b1;
    rsp_ready_i = '0;
    if (hold == 0) rsp_ready_i[idx] = 1'b1;
    for (int k = 0; k < 50 && t_acc < 0; k++) begin
      @(negedge clk);
      if (req_ready_o[idx]) t_acc = cyc;
      step();
    end
    req_valid_i = bg;
    for (int k = 0; k < 60 && t_rsp < 0; k++) begin
      @(negedge clk);
      if (rsp_valid_o != 0) begin
        t_rsp = cyc;
        p = rsp_product_o;
        f = rsp_flags_o;
        v = rsp_valid_o;
      end
      step();
    end
    if (hold > 0) begin
      repeat (hold - 1) step();
      rsp_ready_i[idx] = 1'b1;
      step();
    end
    rsp_ready_i = '0;
    req_valid_i = '0;
    chk("accept_seen", (t_acc >= 0), 1);
    chk("rsp_seen", (t_rsp >= 0), 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int          ta, tr, s0;
    logic [31:0] p;
    logic [4:0]  f;
    logic [N-1:0] v;
    logic [N-1:0] got;
    int          exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req_valid_i = '1;
    req_a_i = {$urandom, $urandom, $urandom, $urandom};
    req_b_i = {$urandom, $urandom, $urandom, $urandom};
    rsp_ready_i = '0;
    stub_fixed = 1'b1;
    stub_delay = 0;
    stub_prod = '0;
    stub_flg = '0;
    #12;
    chk_all_zero("reset");
    req_valid_i = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // All requesters valid from reset, responses taken at once.
    stub_delay = 2;
    stub_prod = 32'h3F80_0000;
    rsp_ready_i = '1;
    req_valid_i = '1;
    for (int k = 0; k < 200 && grants.size() < 5; k++) step();
    req_valid_i = '0;
    wait_idle();
    rsp_ready_i = '0;
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", grants[i], exp_g[i]);

    // Single request, 2.0 * 3.0.
    s0 = n_starts;
    stub_prod = 32'h40C0_0000;
    stub_flg = 4'b0000;
    run_txn(0, 32'h4000_0000, 32'h4040_0000, 3, 0, '0, ta, tr, p, f, v);
    chk("t1_latency", tr - ta, 5);
    chk("t1_product", p, 32'h40C0_0000);
    chk("t1_flags", f, 5'b00000);
    chk("t1_valid", v, 4'b0001);
    chk("t1_starts", n_starts - s0, 1);

    // Watchdog, coincident done/timeout, last-cycle miss, then normal service.
    run_txn(3, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, '0, ta, tr, p, f, v);
    chk("t3_latency", tr - ta, TO + 1);
    chk("t3_product", p, 32'h7FC0_0000);
    chk("t3_flags", f, 5'b10000);
    stub_prod = 32'h3F80_0000;
    run_txn(1, 32'h3F80_0000, 32'h3F80_0000, TO - 1, 0, '0, ta, tr, p, f, v);
    chk("tc_latency", tr - ta, TO + 1);
    chk("tc_product", p, 32'h3F80_0000);
    chk("tc_flags", f, 5'b00000);
    run_txn(2, 32'h3F80_0000, 32'h3F80_0000, TO, 0, '0, ta, tr, p, f, v);
    chk("tl_product", p, 32'h7FC0_0000);
    chk("tl_flags", f, 5'b10000);
    stub_prod = 32'h1234_5678;
    stub_flg = 4'b1000;
    run_txn(0, 32'h0000_0001, 32'h0000_0002, 1, 0, '0, ta, tr, p, f, v);
    chk("t3n_latency", tr - ta, 3);
    chk("t3n_product", p, 32'h1234_5678);
    chk("t3n_flags", f, 5'b01000);

    // Response held off for 5 cycles while others request.
    stub_prod = 32'h4049_0FDB;
    stub_flg = 4'b0000;
    run_txn(2, 32'h4049_0FDB, 32'h3F80_0000, 4, 5, 4'b1011, ta, tr, p, f, v);
    chk("t4_product", p, 32'h4049_0FDB);
    chk("t4_valid", v, 4'b0100);

    // Exception flags pass through.
    stub_prod = 32'h7FC0_0000;
    stub_flg = 4'b0001;
    run_txn(3, 32'h7FC0_0000, 32'h3F80_0000, 5, 0, '0, ta, tr, p, f, v);
    chk("t5_nan_flags", f, 5'b00001);
    stub_prod = 32'h7F80_0000;
    stub_flg = 4'b0110;
    run_txn(1, 32'h7F7F_FFFF, 32'h4000_0000, 5, 0, '0, ta, tr, p, f, v);
    chk("t5_ovf_flags", f, 5'b00110);

    // Reset in the middle of WAIT, late done, then priority restarts at requester 0.
    stub_delay = 6;
    stub_prod = 32'h1111_1111;
    stub_flg = 4'b0001;
    req_valid_i = 4'b0100;
    ta = -1;
    for (int k = 0; k < 50 && ta < 0; k++) begin
      @(negedge clk);
      if (req_ready_o[2]) ta = cyc;
      step();
    end
    chk("t6_accept", (ta >= 0), 1);
    req_valid_i = '0;
    step();
    step();
    req_valid_i = '1;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    req_valid_i = '0;
    step();
    step();
    rst_n = 1'b1;
    stub_delay = 2;
    repeat (4) step();
    req_valid_i = 4'b1101;
    got = '0;
    for (int k = 0; k < 20 && got == '0; k++) begin
      @(negedge clk);
      got = req_ready_o;
      step();
    end
    chk("t6_first_grant", got, 4'b0001);
    req_valid_i = '0;
    rsp_ready_i = '1;
    wait_idle();
    rsp_ready_i = '0;

    // Random traffic against the model.
    s0 = grants.size();
    stub_fixed = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      req_valid_i = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a_i[32*i +: 32] = $urandom;
        req_b_i[32*i +: 32] = $urandom;
      end
      rsp_ready_i = N'($urandom);
      step();
    end
    req_valid_i = '0;
    rsp_ready_i = '1;
    wait_idle();
    chk("random_progress", (grants.size() - s0 > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
